mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mips_pkg.sv | 19 +
 rtl/mem_wb_reg.sv | 43 ++++
 rtl/mem_access_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage of the MIPS pipeline.
//   state_t          - memory-access FSM states (IDLE, REQ)
//   DATA_W           - datapath width
//   TIMEOUT_CYC_DEF  - default cap on cycles spent waiting for dm_ack
//   WB_REGWRITE/WB_MEMTOREG - bit positions inside the 2-bit WB control field
package mips_pkg;

  localparam int DATA_W          = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
//   clk, rst         - clock, asynchronous active-low reset (clears everything)
//   load             - capture alu/wn/wb (and rdata when rdata_load) this edge
//   bubble           - clear only the WB controls so the slot does nothing
//   rdata_load       - with load, also capture rdata_next (loads only)
//   *_next           - values to capture
//   *_reg            - registered MEM/WB contents
// With neither load nor bubble the register holds.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic              rdata_load,
  input  logic [DATA_W-1:0] alu_next,
  input  logic [DATA_W-1:0] rdata_next,
  input  logic [4:0]        wn_next,
  input  logic [1:0]        wb_next,
  output logic [DATA_W-1:0] alu_reg,
  output logic [DATA_W-1:0] rdata_reg,
  output logic [4:0]        wn_reg,
  output logic [1:0]        wb_reg
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_reg   <= '0;
      rdata_reg <= '0;
      wn_reg    <= '0;
      wb_reg    <= '0;
    end else if (load) begin
      alu_reg <= alu_next;
      wn_reg  <= wn_next;
      wb_reg  <= wb_next;
      if (rdata_load) rdata_reg <= rdata_next;
    end else if (bubble) begin
      wb_reg <= '0;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, waits for dm_ack with a
// timeout, and feeds the MEM/WB register.
//   clk, rst                     - clock, asynchronous active-low reset
//   alu_in, rd2_in, wn_in, wb_in - EX/MEM result/address, store data, dest reg, WB controls
//   mem_read, mem_write          - EX/MEM memory controls (both high = write)
//   dm_req, dm_we, dm_addr, dm_wdata - data-memory request side
//   dm_ack, dm_rdata             - data-memory completion and read data
//   stall                        - freezes upstream pipeline registers
//   rdata_out, alu_out, wn_out, wb_out - MEM/WB register contents
//   err_align, err_timeout       - sticky error flags, cleared only by reset
// Memory-op latency is issue cycle + REQ cycles: 2 minimum, TIMEOUT_CYC+1 max.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [4:0]        wn_in,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [1:0]        wb_in,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [4:0]        wn_out,
  output logic [1:0]        wb_out,
  output logic              err_align,
  output logic              err_timeout
);

  localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_we;
  logic [4:0]        req_wn;
  logic [1:0]        req_wb;

  logic              mem_op;
  logic              aligned;
  logic              timed_out;
  logic              stall_c;
  logic              wb_load;
  logic              wb_bubble;
  logic              rd_load;
  logic [DATA_W-1:0] alu_next;
  logic [4:0]        wn_next;
  logic [1:0]        wb_next;

  assign mem_op    = mem_read | mem_write;
  assign aligned   = (alu_in[1:0] == 2'b00);
  assign timed_out = (wait_cnt == LAST_WAIT);

  // Stage control: decide stall and what the MEM/WB register does this edge.
  always_comb begin
    stall_c   = 1'b0;
    wb_load   = 1'b0;
    wb_bubble = 1'b0;
    rd_load   = 1'b0;
    alu_next  = alu_in;
    wn_next   = wn_in;
    wb_next   = wb_in;
    case (state)
      IDLE: begin
        if (mem_op) begin
          // Aligned ops hold MEM/WB at the issue edge; the result lands on ack.
          if (aligned) stall_c = 1'b1;
          else         wb_bubble = 1'b1;
        end else begin
          wb_load = 1'b1;
        end
      end
      REQ: begin
        // Completion uses the latched copy of the instruction, not live inputs.
        alu_next = req_addr;
        wn_next  = req_wn;
        wb_next  = req_wb;
        if (dm_ack) begin
          wb_load = 1'b1;
          rd_load = ~req_we;
        end else if (timed_out) begin
          wb_bubble = 1'b1;
        end else begin
          stall_c   = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset forces IDLE asynchronously, but live inputs could still look like a
  // memory op, so the stall is masked explicitly while in reset.
  assign stall = rst & stall_c;

  // FSM, wait counter, latched request and sticky errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_we      <= 1'b0;
      req_wn      <= '0;
      req_wb      <= '0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (aligned) begin
              state     <= REQ;
              wait_cnt  <= '0;
              req_addr  <= alu_in;
              req_wdata <= rd2_in;
              req_we    <= mem_write;
              req_wn    <= wn_in;
              req_wb    <= wb_in;
            end else begin
              err_align <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dm_ack || timed_out) begin
            // Ack wins over a coincident timeout.
            state     <= IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_we    <= 1'b0;
            if (!dm_ack) err_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request side is driven from registered state only; latches clear on exit.
  assign dm_req   = (state == REQ);
  assign dm_we    = req_we;
  assign dm_addr  = req_addr;
  assign dm_wdata = req_wdata;

  mem_wb_reg u_mem_wb (
    .clk        (clk),
    .rst        (rst),
    .load       (wb_load),
    .bubble     (wb_bubble),
    .rdata_load (rd_load),
    .alu_next   (alu_next),
    .rdata_next (dm_rdata),
    .wn_next    (wn_next),
    .wb_next    (wb_next),
    .alu_reg    (alu_out),
    .rdata_reg  (rdata_out),
    .wn_reg     (wn_out),
    .wb_reg     (wb_out)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_in, rd2_in, dm_rdata;
  logic [4:0]  wn_in;
  logic        mem_write, mem_read, dm_ack;
  logic [1:0]  wb_in;
  logic        dm_req, dm_we, stall, err_align, err_timeout;
  logic [31:0] dm_addr, dm_wdata, rdata_out, alu_out;
  logic [4:0]  wn_out;
  logic [1:0]  wb_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .alu_in(alu_in), .rd2_in(rd2_in), .wn_in(wn_in),
    .mem_write(mem_write), .mem_read(mem_read), .wb_in(wb_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
    .rdata_out(rdata_out), .alu_out(alu_out), .wn_out(wn_out), .wb_out(wb_out),
    .err_align(err_align), .err_timeout(err_timeout)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [4:0]  wn;
    logic [1:0]  wb;
    logic [31:0] e_alu;
    logic [4:0]  e_wn;
    logic [1:0]  e_wb;
    logic        e_align;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [31:0] alu,
                        input logic [31:0] rd2, input logic [4:0] wn, input logic [1:0] wb);
    mem_read  = rd;
    mem_write = wr;
    alu_in    = alu;
    rd2_in    = rd2;
    wn_in     = wn;
    wb_in     = wb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    int stall_cycles;
    logic last_stall;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010,  5'd3, 2'b10, 32'h0000_0010,  5'd3, 2'b10, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 5'd31, 2'b11, 32'hFFFF_FFFC, 5'd31, 2'b11, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h8000_0001,  5'd7, 2'b01, 32'h8000_0001,  5'd7, 2'b01, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0022,  5'd5, 2'b11, 32'h8000_0001,  5'd7, 2'b00, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0041,  5'd2, 2'b00, 32'h8000_0001,  5'd7, 2'b00, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_1234,  5'd9, 2'b10, 32'h0000_1234,  5'd9, 2'b10, 1'b1};

    rst = 1'b0;
    set_op(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    #1;
    chk("reset_alu_out", alu_out, 32'h0);
    chk("reset_wb_out", {30'h0, wb_out}, 32'h0);
    chk("reset_dm_req", {31'h0, dm_req}, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    chk("reset_errs", {30'h0, err_align, err_timeout}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single-cycle ops from IDLE: pass-through and misaligned bubbles.
    for (int i = 0; i < 6; i++) begin
      set_op(vecs[i].rd, vecs[i].wr, vecs[i].alu, 32'h0, vecs[i].wn, vecs[i].wb);
      #1;
      chk($sformatf("v%0d_stall", i), {31'h0, stall}, 32'h0);
      tick();
      chk($sformatf("v%0d_alu_out", i), alu_out, vecs[i].e_alu);
      chk($sformatf("v%0d_wn_out", i), {27'h0, wn_out}, {27'h0, vecs[i].e_wn});
      chk($sformatf("v%0d_wb_out", i), {30'h0, wb_out}, {30'h0, vecs[i].e_wb});
      chk($sformatf("v%0d_err_align", i), {31'h0, err_align}, {31'h0, vecs[i].e_align});
      chk($sformatf("v%0d_dm_req", i), {31'h0, dm_req}, 32'h0);
      chk($sformatf("v%0d_rdata_out", i), rdata_out, 32'h0);
    end

    // Error flags clear only through reset.
    set_op(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
    tick();
    chk("align_sticky", {31'h0, err_align}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("align_cleared_by_reset", {31'h0, err_align}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Load from 0x20, ack on third REQ cycle.
    set_op(1'b1, 1'b0, 32'h20, 32'h0, 5'd4, 2'b11);
    #1;
    chk("ld_issue_stall", {31'h0, stall}, 32'h1);
    chk("ld_issue_req", {31'h0, dm_req}, 32'h0);
    tick();
    chk("ld_r1_req", {31'h0, dm_req}, 32'h1);
    chk("ld_r1_addr", dm_addr, 32'h20);
    chk("ld_r1_we", {31'h0, dm_we}, 32'h0);
    chk("ld_r1_stall", {31'h0, stall}, 32'h1);
    tick();
    chk("ld_bubble1_wb", {30'h0, wb_out}, 32'h0);
    chk("ld_r2_stall", {31'h0, stall}, 32'h1);
    tick();
    chk("ld_bubble2_wb", {30'h0, wb_out}, 32'h0);
    dm_ack   = 1'b1;
    dm_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_ack_stall", {31'h0, stall}, 32'h0);
    chk("ld_ack_req", {31'h0, dm_req}, 32'h1);
    tick();
    dm_ack = 1'b0;
    set_op(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
    chk("ld_rdata_out", rdata_out, 32'hDEAD_BEEF);
    chk("ld_wb_out", {30'h0, wb_out}, 32'h3);
    chk("ld_alu_out", alu_out, 32'h20);
    chk("ld_wn_out", {27'h0, wn_out}, 32'd4);
    chk("ld_done_req", {31'h0, dm_req}, 32'h0);

    // Store to 0x24 with both controls high (treated as write), immediate ack.
    tick();
    set_op(1'b1, 1'b1, 32'h24, 32'h55, 5'd0, 2'b00);
    #1;
    chk("st_issue_stall", {31'h0, stall}, 32'h1);
    tick();
    dm_ack   = 1'b1;
    dm_rdata = 32'h1111_1111;
    #1;
    chk("st_we", {31'h0, dm_we}, 32'h1);
    chk("st_addr", dm_addr, 32'h24);
    chk("st_wdata", dm_wdata, 32'h55);
    chk("st_ack_stall", {31'h0, stall}, 32'h0);
    tick();
    dm_ack = 1'b0;
    set_op(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
    chk("st_done_we", {31'h0, dm_we}, 32'h0);
    chk("st_done_req", {31'h0, dm_req}, 32'h0);
    chk("st_rdata_kept", rdata_out, 32'hDEAD_BEEF);
    chk("st_alu_out", alu_out, 32'h24);

    // Ack on the last allowed REQ cycle completes normally.
    tick();
    set_op(1'b1, 1'b0, 32'h30, 32'h0, 5'd11, 2'b11);
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("edge_req", {31'h0, dm_req}, 32'h1);
    dm_ack   = 1'b1;
    dm_rdata = 32'hCAFE_F00D;
    #1;
    chk("edge_stall", {31'h0, stall}, 32'h0);
    tick();
    dm_ack = 1'b0;
    set_op(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
    chk("edge_rdata", rdata_out, 32'hCAFE_F00D);
    chk("edge_wb_out", {30'h0, wb_out}, 32'h3);
    chk("edge_no_timeout", {31'h0, err_timeout}, 32'h0);

    // Load with no ack: timeout after exactly 16 REQ cycles.
    tick();
    set_op(1'b1, 1'b0, 32'h40, 32'h0, 5'd6, 2'b11);
    tick();
    req_cycles   = 0;
    stall_cycles = 0;
    last_stall   = 1'b1;
    while (dm_req && req_cycles < 40) begin
      req_cycles++;
      last_stall = stall;
      if (stall) stall_cycles++;
      tick();
    end
    set_op(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
    chk("to_req_cycles", req_cycles, 32'd16);
    chk("to_stall_cycles", stall_cycles, 32'd15);
    chk("to_last_stall", {31'h0, last_stall}, 32'h0);
    chk("to_err_timeout", {31'h0, err_timeout}, 32'h1);
    chk("to_wb_out", {30'h0, wb_out}, 32'h0);
    chk("to_rdata_kept", rdata_out, 32'hCAFE_F00D);

    // Late ack in IDLE is ignored; a plain ALU op goes through.
    set_op(1'b0, 1'b0, 32'h50, 32'h0, 5'd1, 2'b10);
    dm_ack   = 1'b1;
    dm_rdata = 32'h2222_2222;
    #1;
    chk("late_ack_stall", {31'h0, stall}, 32'h0);
    tick();
    dm_ack = 1'b0;
    chk("late_ack_req", {31'h0, dm_req}, 32'h0);
    chk("late_ack_alu", alu_out, 32'h50);
    chk("late_ack_rdata", rdata_out, 32'hCAFE_F00D);
    chk("late_err_timeout", {31'h0, err_timeout}, 32'h1);

    // Reset in the middle of a request.
    set_op(1'b1, 1'b0, 32'h60, 32'h0, 5'd8, 2'b11);
    tick();
    tick();
    chk("rst_mid_req_before", {31'h0, dm_req}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_req", {31'h0, dm_req}, 32'h0);
    chk("rst_mid_stall", {31'h0, stall}, 32'h0);
    chk("rst_mid_addr", dm_addr, 32'h0);
    chk("rst_mid_alu", alu_out, 32'h0);
    chk("rst_mid_rdata", rdata_out, 32'h0);
    chk("rst_mid_errs", {30'h0, err_align, err_timeout}, 32'h0);
    @(negedge clk);
    set_op(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
    rst = 1'b1;
    tick();
    chk("post_rst_req", {31'h0, dm_req}, 32'h0);
    set_op(1'b1, 1'b0, 32'h70, 32'h0, 5'd10, 2'b11);
    tick();
    chk("post_rst_issue", {31'h0, dm_req}, 32'h1);
    dm_ack   = 1'b1;
    dm_rdata = 32'h1234_5678;
    tick();
    dm_ack = 1'b0;
    set_op(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
    chk("post_rst_rdata", rdata_out, 32'h1234_5678);
    chk("post_rst_alu", alu_out, 32'h70);
    chk("post_rst_wb", {30'h0, wb_out}, 32'h3);
    chk("post_rst_errs", {30'h0, err_align, err_timeout}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
